// File: rtl/data_mem_responder.sv
// Data-port memory responder: 256x8 RAM answering core requests over Mem_Ctrl/dacq, plus a host load port.
// Latency: dacq rises LAT edges after the accepting edge; a full access takes at least LAT+3 cycles.
// Flow control: one access at a time; the request must drop to idle before the next one is accepted. Optional err output under DMEM_ERR_EN.
module data_mem_responder #(
  parameter int LAT  = 2,
  parameter int CNTW = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Mem_Ctrl,
  input  logic [7:0] DAddress,
  input  logic [7:0] Ddout,
  output logic [7:0] Ddin,
  output logic       dacq,
  input  logic       ld_en,
  input  logic [7:0] ld_addr,
  input  logic [7:0] ld_data
`ifdef DMEM_ERR_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdat_q, wdat_d;
  logic [7:0]        ddin_q, ddin_d;
  logic              dacq_q, dacq_d;
  logic [7:0]        mem_q [256];

  logic [1:0]        cmd;
  logic              commit;
  logic              core_we;

  // Upper command bits belong to other consumers of Mem_Ctrl.
  logic              unused_ctrl;
  assign unused_ctrl = ^Mem_Ctrl[3:2];

  assign cmd     = Mem_Ctrl[1:0];
  // The access completes on the BUSY edge where the wait counter has run out.
  assign commit  = (state_q == S_BUSY) && (cnt_q == '0);
  assign core_we = commit && (op_q == OP_WR);

  assign Ddin = ddin_q;
  assign dacq = dacq_q;

  // Next-state and datapath: latch the request on acceptance, count wait states, complete once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    ddin_d  = ddin_q;
    dacq_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd == OP_RD || cmd == OP_WR) begin
          op_d    = cmd;
          addr_d  = DAddress;
          wdat_d  = Ddout;
          cnt_d   = CNTW'(LAT - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_ACK;
          dacq_d  = 1'b1;
          // Read returns the RAM contents before this edge's writes/loads.
          if (op_q == OP_RD) begin
            ddin_d = mem_q[addr_q];
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_ACK: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Wait for the core to drop its request so a held request is not served twice.
        if (cmd == OP_IDLE) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and datapath registers with synchronous reset; reset aborts any in-flight access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      ddin_q  <= '0;
      dacq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      ddin_q  <= ddin_d;
      dacq_q  <= dacq_d;
    end
  end

  // RAM write port: the host load is applied last so it wins an address collision with a core write.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (core_we) begin
        mem_q[addr_q] <= wdat_q;
      end
      if (ld_en) begin
        mem_q[ld_addr] <= ld_data;
      end
    end
  end

`ifdef DMEM_ERR_EN
  logic err_q, err_d;

  // Flag an illegal command in IDLE, or a conflicting command while an access is in progress.
  always_comb begin
    err_d = 1'b0;
    if (state_q == S_IDLE && cmd == OP_ILL) begin
      err_d = 1'b1;
    end
    if (state_q == S_BUSY && cmd != OP_IDLE && cmd != op_q) begin
      err_d = 1'b1;
    end
  end

  // One-cycle-delayed error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized accesses against a RAM/transaction model.
// Latency: expects dacq exactly LAT edges after acceptance, Ddin updated only by completed reads.
// Flow control: requests held through release must produce a single dacq.
module tb_data_mem_responder;

  localparam int LAT  = 2;
  localparam int CNTW = 4;

  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;

  logic       CLK;
  logic       RST;
  logic [3:0] Mem_Ctrl;
  logic [7:0] DAddress;
  logic [7:0] Ddout;
  logic [7:0] Ddin;
  logic       dacq;
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
`ifdef DMEM_ERR_EN
  logic       err;
`endif

  data_mem_responder #(.LAT(LAT), .CNTW(CNTW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Mem_Ctrl (Mem_Ctrl),
    .DAddress (DAddress),
    .Ddout    (Ddout),
    .Ddin     (Ddin),
    .dacq     (dacq),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
`ifdef DMEM_ERR_EN
    ,
    .err      (err)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] mm [256];
  logic [7:0] exp_ddin;
  bit         bg;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, called and returning at a falling edge. mode: 0 no load, 1 forced load, 2 random load.
  // The model applies the core access first, then the host load, so the host wins a same-address collision
  // and a read sees the RAM as it was before the edge.
  task automatic step(input bit commit, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                      input int mode, input logic [7:0] fla, input logic [7:0] flv);
    logic       le;
    logic [7:0] la;
    logic [7:0] lv;
    le = 1'b0;
    la = fla;
    lv = flv;
    if (mode == 1) begin
      le = 1'b1;
    end else if (mode == 2) begin
      le = ($urandom_range(0, 2) == 0);
      la = ($urandom_range(0, 1) == 1) ? a : 8'($urandom);
      lv = 8'($urandom);
    end
    ld_en   = le;
    ld_addr = la;
    ld_data = lv;
    @(negedge CLK);
    if (commit) begin
      if (op == OP_RD) exp_ddin = mm[a];
      else if (op == OP_WR) mm[a] = d;
    end
    if (le) mm[la] = lv;
    ld_en = 1'b0;
  endtask

  // A complete core transaction from IDLE back to IDLE, with bus noise during the wait states.
  task automatic access(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d, input int hold,
                        input int cmode, input logic [7:0] cla, input logic [7:0] clv);
    int bm;
    bm = bg ? 2 : 0;
    Mem_Ctrl = {2'($urandom), op};
    DAddress = a;
    Ddout    = d;
    step(1'b0, op, a, d, bm, 8'h00, 8'h00);
    check("accept_dacq", 8'(dacq), 8'h00);
    for (int e = 1; e <= LAT; e++) begin
      Mem_Ctrl = {2'($urandom), op};
      DAddress = 8'($urandom);
      Ddout    = 8'($urandom);
      step(e == LAT, op, a, d, (e == LAT) ? cmode : bm, cla, clv);
      check("busy_dacq", 8'(dacq), 8'(e == LAT));
`ifdef DMEM_ERR_EN
      check("busy_err", 8'(err), 8'h00);
`endif
    end
    check("ack_ddin", Ddin, exp_ddin);
    for (int h = 0; h < hold; h++) begin
      Mem_Ctrl = {2'($urandom), 2'($urandom_range(1, 3))};
      step(1'b0, op, a, d, bm, 8'h00, 8'h00);
      check("release_dacq", 8'(dacq), 8'h00);
      check("release_ddin", Ddin, exp_ddin);
    end
    Mem_Ctrl = {2'($urandom), 2'b00};
    step(1'b0, op, a, d, bm, 8'h00, 8'h00);
    check("drop_dacq", 8'(dacq), 8'h00);
  endtask

  // Idle cycles mixing 00 and the illegal 11 command; neither may start an access.
  task automatic idle(input int n);
    logic [1:0] c;
    for (int i = 0; i < n; i++) begin
      c = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      Mem_Ctrl = {2'($urandom), c};
      step(1'b0, 2'b00, 8'($urandom), 8'h00, bg ? 2 : 0, 8'h00, 8'h00);
      check("idle_dacq", 8'(dacq), 8'h00);
      check("idle_ddin", Ddin, exp_ddin);
`ifdef DMEM_ERR_EN
      check("idle_err", 8'(err), 8'(c == 2'b11));
`endif
    end
    Mem_Ctrl = 4'h0;
  endtask

  initial begin
    RST      = 1'b1;
    Mem_Ctrl = 4'h0;
    DAddress = 8'h00;
    Ddout    = 8'h00;
    ld_en    = 1'b0;
    ld_addr  = 8'h00;
    ld_data  = 8'h00;
    exp_ddin = 8'h00;
    bg       = 1'b0;
    @(negedge CLK);

    // Reset holds outputs quiet.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
      check("rst_dacq", 8'(dacq), 8'h00);
      check("rst_ddin", Ddin, 8'h00);
    end
    RST = 1'b0;
    step(1'b0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    check("post_rst_dacq", 8'(dacq), 8'h00);
    check("post_rst_ddin", Ddin, 8'h00);

    // Give every RAM location a known value through the host port.
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 2'b00, 8'h00, 8'h00, 1, 8'(i), 8'($urandom));
    end

    // Host load then read.
    step(1'b0, 2'b00, 8'h00, 8'h00, 1, 8'h3C, 8'hA5);
    access(OP_RD, 8'h3C, 8'h00, 2, 0, 8'h00, 8'h00);
    check("load_read", Ddin, 8'hA5);
    idle(2);
    check("load_read_hold", Ddin, 8'hA5);

    // Write then read, with the request held through release.
    access(OP_WR, 8'h10, 8'h5A, 3, 0, 8'h00, 8'h00);
    access(OP_RD, 8'h10, 8'h00, 1, 0, 8'h00, 8'h00);
    check("wr_rd", Ddin, 8'h5A);

    // Host load collides with core write: same address, then different addresses.
    access(OP_WR, 8'h20, 8'h11, 1, 1, 8'h20, 8'h22);
    access(OP_RD, 8'h20, 8'h00, 1, 0, 8'h00, 8'h00);
    check("coll_same", Ddin, 8'h22);
    access(OP_WR, 8'h20, 8'h11, 1, 1, 8'h21, 8'h22);
    access(OP_RD, 8'h20, 8'h00, 1, 0, 8'h00, 8'h00);
    check("coll_diff_20", Ddin, 8'h11);
    access(OP_RD, 8'h21, 8'h00, 1, 0, 8'h00, 8'h00);
    check("coll_diff_21", Ddin, 8'h22);

    // Host load collides with core read: read returns the old value.
    step(1'b0, 2'b00, 8'h00, 8'h00, 1, 8'h30, 8'h77);
    access(OP_RD, 8'h30, 8'h00, 1, 1, 8'h30, 8'h88);
    check("coll_read_old", Ddin, 8'h77);
    access(OP_RD, 8'h30, 8'h00, 1, 0, 8'h00, 8'h00);
    check("coll_read_new", Ddin, 8'h88);

    // Reset in the middle of a write aborts it.
    step(1'b0, 2'b00, 8'h00, 8'h00, 1, 8'h05, 8'h00);
    Mem_Ctrl = {2'b00, OP_WR};
    DAddress = 8'h05;
    Ddout    = 8'hFF;
    step(1'b0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    RST      = 1'b1;
    Mem_Ctrl = 4'h0;
    exp_ddin = 8'h00;
    for (int i = 0; i < LAT + 1; i++) begin
      step(1'b0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
      check("midrst_dacq", 8'(dacq), 8'h00);
      check("midrst_ddin", Ddin, 8'h00);
    end
    RST = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      step(1'b0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
      check("after_rst_dacq", 8'(dacq), 8'h00);
    end
    access(OP_RD, 8'h05, 8'h00, 1, 0, 8'h00, 8'h00);
    check("midrst_no_commit", Ddin, 8'h00);

    // Illegal command in IDLE.
    Mem_Ctrl = 4'h3;
    step(1'b0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    check("ill_dacq", 8'(dacq), 8'h00);
`ifdef DMEM_ERR_EN
    check("ill_err", 8'(err), 8'h01);
`endif
    Mem_Ctrl = 4'h0;
    step(1'b0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    check("ill_dacq2", 8'(dacq), 8'h00);
`ifdef DMEM_ERR_EN
    check("ill_err_clear", 8'(err), 8'h00);
`endif
    idle(6);

    // Randomized accesses with background host loads on a small address window.
    bg = 1'b1;
    for (int t = 0; t < 60; t++) begin
      access(2'($urandom_range(1, 2)), 8'($urandom_range(0, 15)), 8'($urandom),
             $urandom_range(1, 3), 2, 8'h00, 8'h00);
      idle($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
